sht21_meas_seq: RTL

- Measurement sequencer for the SHT21 humidity/temperature sensor.
- Drives the IIC byte engine, which wraps the SCL generator and the SDA shifter, through a one-outstanding command/response handshake.
- Runs a temperature measurement and then a humidity measurement in no-hold-master mode, polling the sensor until conversion completes.
- Checks CRC-8 on each result and presents raw results plus error pulses to the application logic.

---
 rtl/sht21_meas_seq_if.sv | 26 ++
 rtl/sht21_meas_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sht21_meas_seq_if.sv
// Command/response link between the SHT21 measurement sequencer and the IIC byte engine.
//   cmd_valid/cmd_ready : one command offered and accepted (valid/ready)
//   cmd_op              : 0=START 1=WRITE 2=READ_ACK 3=READ_NACK 4=STOP
//   cmd_data            : byte to write (WRITE only, else 0)
//   rsp_valid           : one-cycle completion of the accepted command
//   rsp_data            : byte read (READ_*)
//   rsp_nack            : slave NACKed a WRITE
interface sht21_meas_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );
endinterface

// File: rtl/sht21_meas_seq.sv
// SHT21 measurement sequencer. Runs a no-hold-master temperature measurement followed by a
// humidity measurement, polling the sensor until conversion completes, checks CRC-8 on each
// result and publishes both raw words together.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   start          : one-cycle request for a T+RH pair (ignored while busy)
//   auto_en        : repeat pairs every AUTO_PERIOD cycles of idle time
//   busy           : pair in progress
//   bus            : command/response link to the IIC byte engine (master side)
//   temp_raw/rh_raw: last good words, status bits [1:0] cleared
//   data_valid     : pulse when both words update
//   crc_err/nack_err/timeout_err : one-cycle error pulses
module sht21_meas_seq #(
  parameter logic [6:0]  DEV_ADDR    = 7'h40,
  parameter logic [31:0] MEAS_WAIT   = 32'd2_000_000,
  parameter logic [31:0] POLL_WAIT   = 32'd100_000,
  parameter logic [7:0]  MAX_POLL    = 8'd100,
  parameter logic [31:0] AUTO_PERIOD = 32'd100_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    auto_en,
  output logic                    busy,
  sht21_meas_seq_if.master        bus,
  output logic [15:0]             temp_raw,
  output logic [15:0]             rh_raw,
  output logic                    data_valid,
  output logic                    crc_err,
  output logic                    nack_err,
  output logic                    timeout_err
);

  localparam logic [2:0] OpStart = 3'd0;
  localparam logic [2:0] OpWrite = 3'd1;
  localparam logic [2:0] OpRdAck = 3'd2;
  localparam logic [2:0] OpRdNak = 3'd3;
  localparam logic [2:0] OpStop  = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StStart, StWrAddrW, StWrCmd, StStop1, StWaitMeas, StPollStart, StWrAddrR,
    StPollStop, StPollWait, StRdMsb, StRdLsb, StRdCrc, StStop2, StCheck, StErrStop
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d, pend_q, pend_d;
  logic [2:0]  cmd_op_q, cmd_op_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [31:0] timer_q, timer_d, auto_tmr_q, auto_tmr_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        hum_q, hum_d, to_q, to_d;
  logic [7:0]  msb_q, msb_d, lsb_q, lsb_d, crc_q, crc_d;
  logic [15:0] hold_q, hold_d, temp_q, temp_d, rh_q, rh_d;
  logic        dv_q, dv_d, crc_err_q, crc_err_d, nack_err_q, nack_err_d, to_err_q, to_err_d;
  logic        busy_q, busy_d;

  logic        rsp_done, auto_hit, crc_ok;
  logic [15:0] word;

  // CRC-8, poly 0x31, init 0x00, MSB first over {msb, lsb}.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // A response only counts while our accepted command is outstanding.
  assign rsp_done = pend_q && bus.rsp_valid;
  assign auto_hit = auto_en && (auto_tmr_q == AUTO_PERIOD - 32'd1);
  assign crc_ok   = (crc8({msb_q, lsb_q}) == crc_q);
  assign word     = {msb_q, lsb_q & 8'hFC};

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_data_d  = cmd_data_q;
    pend_d      = pend_q;
    timer_d     = timer_q;
    auto_tmr_d  = '0;
    poll_cnt_d  = poll_cnt_q;
    hum_d       = hum_q;
    to_d        = to_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    crc_d       = crc_q;
    hold_d      = hold_q;
    temp_d      = temp_q;
    rh_d        = rh_q;
    dv_d        = 1'b0;
    crc_err_d   = 1'b0;
    nack_err_d  = 1'b0;
    to_err_d    = 1'b0;

    if (cmd_valid_q && bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
      pend_d      = 1'b1;
    end
    if (rsp_done) pend_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (auto_en) auto_tmr_d = auto_hit ? auto_tmr_q : auto_tmr_q + 32'd1;
        // busy_q still high in the pulse cycle keeps a back-to-back start out.
        if ((start || auto_hit) && !busy_q) begin
          state_d    = StStart;
          hum_d      = 1'b0;
          auto_tmr_d = '0;
        end
      end
      StStart:     if (rsp_done) state_d = StWrAddrW;
      StWrAddrW, StWrCmd: begin
        if (rsp_done) begin
          if (bus.rsp_nack) begin
            state_d = StErrStop;
            to_d    = 1'b0;
          end else begin
            state_d = (state_q == StWrAddrW) ? StWrCmd : StStop1;
          end
        end
      end
      StStop1: begin
        if (rsp_done) begin
          state_d = StWaitMeas;
          timer_d = '0;
        end
      end
      StWaitMeas: begin
        if (MEAS_WAIT == 32'd0 || timer_q == MEAS_WAIT - 32'd1) begin
          state_d    = StPollStart;
          timer_d    = '0;
          poll_cnt_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StPollStart: if (rsp_done) state_d = StWrAddrR;
      StWrAddrR: begin
        if (rsp_done) begin
          if (!bus.rsp_nack) begin
            state_d = StRdMsb;
          end else if (poll_cnt_q == MAX_POLL - 8'd1) begin
            state_d = StErrStop;
            to_d    = 1'b1;
          end else begin
            state_d = StPollStop;
          end
        end
      end
      StPollStop: begin
        if (rsp_done) begin
          state_d    = StPollWait;
          timer_d    = '0;
          poll_cnt_d = poll_cnt_q + 8'd1;
        end
      end
      StPollWait: begin
        if (POLL_WAIT == 32'd0 || timer_q == POLL_WAIT - 32'd1) begin
          state_d = StPollStart;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StRdMsb: if (rsp_done) begin msb_d = bus.rsp_data; state_d = StRdLsb; end
      StRdLsb: if (rsp_done) begin lsb_d = bus.rsp_data; state_d = StRdCrc; end
      StRdCrc: if (rsp_done) begin crc_d = bus.rsp_data; state_d = StStop2; end
      StStop2: if (rsp_done) state_d = StCheck;
      StCheck: begin
        if (!crc_ok) begin
          crc_err_d = 1'b1;
          state_d   = StIdle;
        end else if (!hum_q) begin
          hold_d  = word;
          hum_d   = 1'b1;
          state_d = StStart;
        end else begin
          temp_d  = hold_q;
          rh_d    = word;
          dv_d    = 1'b1;
          state_d = StIdle;
        end
      end
      StErrStop: begin
        if (rsp_done) begin
          to_err_d   = to_q;
          nack_err_d = !to_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Each command state offers its command once, on entry.
    if (state_d != state_q) begin
      unique case (state_d)
        StStart, StPollStart: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpStart; cmd_data_d = 8'h00;
        end
        StWrAddrW: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpWrite; cmd_data_d = {DEV_ADDR, 1'b0};
        end
        StWrCmd: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpWrite; cmd_data_d = hum_q ? 8'hF5 : 8'hF3;
        end
        StWrAddrR: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpWrite; cmd_data_d = {DEV_ADDR, 1'b1};
        end
        StRdMsb, StRdLsb: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpRdAck; cmd_data_d = 8'h00;
        end
        StRdCrc: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpRdNak; cmd_data_d = 8'h00;
        end
        StStop1, StPollStop, StStop2, StErrStop: begin
          cmd_valid_d = 1'b1; cmd_op_d = OpStop; cmd_data_d = 8'h00;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != StIdle) || dv_d || crc_err_d || nack_err_d || to_err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 3'd0;
      cmd_data_q  <= 8'h00;
      pend_q      <= 1'b0;
      timer_q     <= '0;
      auto_tmr_q  <= '0;
      poll_cnt_q  <= '0;
      hum_q       <= 1'b0;
      to_q        <= 1'b0;
      msb_q       <= '0;
      lsb_q       <= '0;
      crc_q       <= '0;
      hold_q      <= '0;
      temp_q      <= '0;
      rh_q        <= '0;
      dv_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      nack_err_q  <= 1'b0;
      to_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      auto_tmr_q  <= auto_tmr_d;
      poll_cnt_q  <= poll_cnt_d;
      hum_q       <= hum_d;
      to_q        <= to_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      crc_q       <= crc_d;
      hold_q      <= hold_d;
      temp_q      <= temp_d;
      rh_q        <= rh_d;
      dv_q        <= dv_d;
      crc_err_q   <= crc_err_d;
      nack_err_q  <= nack_err_d;
      to_err_q    <= to_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_data  = cmd_data_q;
  assign busy          = busy_q;
  assign temp_raw      = temp_q;
  assign rh_raw        = rh_q;
  assign data_valid    = dv_q;
  assign crc_err       = crc_err_q;
  assign nack_err      = nack_err_q;
  assign timeout_err   = to_err_q;

endmodule
